// File: rtl/stopwatch_vga_render.sv
// rtl/stopwatch_vga_render.sv - BCD stopwatch with lap freeze and seven-segment VGA renderer
module stopwatch_vga_render #(
  parameter int          TICK_DIV = 100000,
  parameter int          X0       = 10,
  parameter int          Y0       = 120,
  parameter int          SEG_T    = 8,
  parameter int          SEG_L    = 32,
  parameter int          PITCH    = 64,
  parameter logic [11:0] FG_COLOR = 12'hF00,
  parameter logic [11:0] BG_COLOR = 12'h000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        i_pix_stb,
  input  logic [9:0]  i_x,
  input  logic [8:0]  i_y,
  input  logic        i_start_stop,
  input  logic        i_lap,
  input  logic        i_clear,
  output logic [3:0]  VGA_R,
  output logic [3:0]  VGA_G,
  output logic [3:0]  VGA_B,
  output logic        o_running,
  output logic        o_lap,
  output logic [35:0] o_time,
  output logic        o_wrap
);

  localparam int            PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_TOP = PW'(TICK_DIV - 1);
  localparam int            T         = SEG_T;
  localparam int            L         = SEG_L;

  logic [PW-1:0] presc_q, presc_d;
  logic          running_q, running_d;
  logic          lap_q, lap_d;
  logic          wrap_q, wrap_d;
  logic [35:0]   time_q, time_d;
  logic [35:0]   disp_q, disp_d;
  logic [11:0]   rgb_q, rgb_d;
  logic          tick;
  logic          carry;
  logic          lit;
  logic          colon_on;
  logic [6:0]    segs;
  logic          xa, xb, xe, xs, ya, yb, yc, yd, yg;
  int            px, py, dx;

  // Digit k counts from H1 (k=0) to m0 (k=8); tens of minutes/seconds stop at 5.
  function automatic logic [3:0] digit_max(int k);
    return (k == 2 || k == 4) ? 4'd5 : 4'd9;
  endfunction

  // Segment pattern ordered {a,b,c,d,e,f,g}.
  function automatic logic [6:0] seg_decode(logic [3:0] v);
    case (v)
      4'd0:    return 7'b1111110;
      4'd1:    return 7'b0110000;
      4'd2:    return 7'b1101101;
      4'd3:    return 7'b1111001;
      4'd4:    return 7'b0110011;
      4'd5:    return 7'b1011011;
      4'd6:    return 7'b1011111;
      4'd7:    return 7'b1110000;
      4'd8:    return 7'b1111111;
      4'd9:    return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic logic in_span(int v, int lo, int len);
    return (v >= lo) && (v < lo + len);
  endfunction

  assign tick = running_q && (presc_q == PRESC_TOP);

  // Prescaler, BCD carry chain, run/lap toggles and the displayed copy; clear overrides all but running.
  always_comb begin
    presc_d = presc_q;
    if (running_q) presc_d = tick ? '0 : presc_q + 1'b1;
    time_d = time_q;
    carry  = tick;
    for (int k = 8; k >= 0; k--) begin
      if (carry) begin
        if (time_q[(8-k)*4 +: 4] == digit_max(k)) begin
          time_d[(8-k)*4 +: 4] = 4'd0;
        end else begin
          time_d[(8-k)*4 +: 4] = time_q[(8-k)*4 +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    wrap_d    = carry;
    running_d = running_q ^ i_start_stop;
    lap_d     = lap_q ^ i_lap;
    disp_d    = lap_q ? disp_q : time_q;
    if (i_clear) begin
      time_d  = '0;
      presc_d = '0;
      disp_d  = '0;
      lap_d   = 1'b0;
      wrap_d  = 1'b0;
    end
  end

  // Hit-test the pixel against every digit's segments and the separators.
  always_comb begin
    px       = {22'd0, i_x};
    py       = {23'd0, i_y};
    lit      = 1'b0;
    segs     = 7'd0;
    dx       = 0;
    xa = 1'b0; xb = 1'b0; xe = 1'b0; xs = 1'b0;
    ya = 1'b0; yb = 1'b0; yc = 1'b0; yd = 1'b0; yg = 1'b0;
    // Blink follows the live millisecond count so it keeps pulsing during a lap freeze.
    colon_on = !running_q || (time_q[11:8] < 4'd5);
    for (int k = 0; k < 9; k++) begin
      dx   = X0 + k * PITCH;
      segs = seg_decode(disp_q[(8-k)*4 +: 4]);
      xa   = in_span(px, dx + T, L);
      xb   = in_span(px, dx + T + L, T);
      xe   = in_span(px, dx, T);
      xs   = in_span(px, dx + 2*T + L + T/2, T);
      ya   = in_span(py, Y0, T);
      yb   = in_span(py, Y0 + T, L);
      yc   = in_span(py, Y0 + 2*T + L, L);
      yd   = in_span(py, Y0 + 2*T + 2*L, T);
      yg   = in_span(py, Y0 + T + L, T);
      lit  = lit | (segs[6] & xa & ya) | (segs[5] & xb & yb) | (segs[4] & xb & yc)
                 | (segs[3] & xa & yd) | (segs[2] & xe & yc) | (segs[1] & xe & yb)
                 | (segs[0] & xa & yg);
      if (k == 1 || k == 3)
        lit = lit | (colon_on & xs & (in_span(py, Y0 + L/2, T) |
                                      in_span(py, Y0 + 2*T + 3*L/2 - T, T)));
      if (k == 5) lit = lit | (xs & yd);
    end
    rgb_d = i_pix_stb ? (lit ? FG_COLOR : BG_COLOR) : rgb_q;
  end

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      presc_q   <= '0;
      running_q <= 1'b0;
      lap_q     <= 1'b0;
      wrap_q    <= 1'b0;
      time_q    <= '0;
      disp_q    <= '0;
      rgb_q     <= '0;
    end else begin
      presc_q   <= presc_d;
      running_q <= running_d;
      lap_q     <= lap_d;
      wrap_q    <= wrap_d;
      time_q    <= time_d;
      disp_q    <= disp_d;
      rgb_q     <= rgb_d;
    end
  end

  assign {VGA_R, VGA_G, VGA_B} = rgb_q;
  assign o_running = running_q;
  assign o_lap     = lap_q;
  assign o_time    = time_q;
  assign o_wrap    = wrap_q;

endmodule

// File: tb/tb_stopwatch_vga_render.sv
// tb/tb_stopwatch_vga_render.sv - randomized self-checking bench for stopwatch_vga_render
module tb_stopwatch_vga_render;

  localparam int          TD    = 4;
  localparam int          X0    = 10;
  localparam int          Y0    = 120;
  localparam int          T     = 8;
  localparam int          L     = 32;
  localparam int          P     = 64;
  localparam logic [11:0] FG    = 12'hF00;
  localparam logic [11:0] BG    = 12'h000;
  localparam int          MAXMS = 100 * 3600 * 1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stb, ss, lp, cl;
  logic [9:0]  px;
  logic [8:0]  py;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        o_running, o_lap, o_wrap;
  logic [35:0] o_time;
  logic [11:0] rgb;

  int errors = 0;
  int checks = 0;

  // Reference model state: time as a plain millisecond count.
  int          m_ms, m_presc, m_disp;
  bit          m_run, m_lap, m_wrap;
  logic [11:0] m_rgb;

  string digit_segs [10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                             "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

  stopwatch_vga_render #(
    .TICK_DIV(TD), .X0(X0), .Y0(Y0), .SEG_T(T), .SEG_L(L), .PITCH(P),
    .FG_COLOR(FG), .BG_COLOR(BG)
  ) dut (
    .CLK(clk), .RST(rst), .i_pix_stb(stb), .i_x(px), .i_y(py),
    .i_start_stop(ss), .i_lap(lp), .i_clear(cl),
    .VGA_R(vga_r), .VGA_G(vga_g), .VGA_B(vga_b),
    .o_running(o_running), .o_lap(o_lap), .o_time(o_time), .o_wrap(o_wrap)
  );

  assign rgb = {vga_r, vga_g, vga_b};

  always #5 clk = ~clk;

  function automatic logic [35:0] to_bcd(int ms);
    int h, mi, s, f;
    h  = ms / 3600000;
    mi = (ms / 60000) % 60;
    s  = (ms / 1000) % 60;
    f  = ms % 1000;
    return {4'(h / 10), 4'(h % 10), 4'(mi / 10), 4'(mi % 10), 4'(s / 10), 4'(s % 10),
            4'(f / 100), 4'((f / 10) % 10), 4'(f % 10)};
  endfunction

  function automatic bit in_box(int x, int y, int x0, int w, int y0, int h);
    return (x >= x0) && (x < x0 + w) && (y >= y0) && (y < y0 + h);
  endfunction

  function automatic bit seg_box(byte s, int x, int y, int dx);
    case (s)
      "a": return in_box(x, y, dx + T,     L, Y0,             T);
      "b": return in_box(x, y, dx + T + L, T, Y0 + T,         L);
      "c": return in_box(x, y, dx + T + L, T, Y0 + 2*T + L,   L);
      "d": return in_box(x, y, dx + T,     L, Y0 + 2*T + 2*L, T);
      "e": return in_box(x, y, dx,         T, Y0 + 2*T + L,   L);
      "f": return in_box(x, y, dx,         T, Y0 + T,         L);
      "g": return in_box(x, y, dx + T,     L, Y0 + T + L,     T);
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit ref_lit(int x, int y, int dms, bit run, int lms);
    logic [35:0] dd;
    bit          r;
    int          dx, dig, sx;
    string       pat;
    dd = to_bcd(dms);
    r  = 1'b0;
    for (int k = 0; k < 9; k++) begin
      dx  = X0 + k * P;
      dig = int'(dd[(8-k)*4 +: 4]);
      pat = digit_segs[dig];
      for (int i = 0; i < pat.len(); i++)
        if (seg_box(pat[i], x, y, dx)) r = 1'b1;
      sx = dx + 2*T + L + T/2;
      if ((k == 1 || k == 3) && (!run || ((lms / 100) % 10) < 5) &&
          (in_box(x, y, sx, T, Y0 + L/2, T) || in_box(x, y, sx, T, Y0 + 2*T + 3*L/2 - T, T)))
        r = 1'b1;
      if (k == 5 && in_box(x, y, sx, T, Y0 + 2*T + 2*L, T)) r = 1'b1;
    end
    return r;
  endfunction

  task automatic model_step();
    bit tick;
    int old_ms;
    bit old_run;
    int old_disp;
    old_ms   = m_ms;
    old_run  = m_run;
    old_disp = m_disp;
    tick     = m_run && (m_presc == TD - 1);
    if (stb) m_rgb = ref_lit(int'(px), int'(py), old_disp, old_run, old_ms) ? FG : BG;
    m_wrap = 1'b0;
    if (m_run) m_presc = tick ? 0 : m_presc + 1;
    if (tick) begin
      m_ms   = (m_ms + 1) % MAXMS;
      m_wrap = (m_ms == 0);
    end
    if (!m_lap) m_disp = old_ms;
    m_run = m_run ^ ss;
    m_lap = m_lap ^ lp;
    if (cl) begin
      m_ms = 0; m_presc = 0; m_disp = 0; m_lap = 1'b0; m_wrap = 1'b0;
    end
  endtask

  task automatic cyc(input bit s, input bit l, input bit c);
    ss = s; lp = l; cl = c;
    @(posedge clk);
    model_step();
    @(negedge clk);
    ss = 1'b0; lp = 1'b0; cl = 1'b0; stb = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; stb = 1'b0; ss = 1'b0; lp = 1'b0; cl = 1'b0; px = '0; py = '0;
    m_ms = 0; m_presc = 0; m_disp = 0; m_run = 0; m_lap = 0; m_wrap = 0; m_rgb = BG;
    repeat (3) @(negedge clk);
    checks++;
    if (o_time !== 36'd0 || o_running !== 1'b0 || o_lap !== 1'b0 || o_wrap !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got time=%h run=%b lap=%b wrap=%b exp all zero",
               o_time, o_running, o_lap, o_wrap);
    end
    checks++;
    if (rgb !== 12'h000) begin
      errors++;
      $display("FAIL reset_rgb got=%h exp=000", rgb);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_run();
    cyc(1, 0, 0);
    for (int i = 0; i < 40; i++) begin
      repeat (100) cyc(0, 0, 0);
      checks++;
      if (o_time !== to_bcd(m_ms)) begin
        errors++;
        $display("FAIL run_track got=%h exp=%h", o_time, to_bcd(m_ms));
      end
    end
    checks++;
    if (o_time !== 36'h000001000 || o_running !== 1'b1) begin
      errors++;
      $display("FAIL run_4000 got time=%h run=%b exp time=000001000 run=1", o_time, o_running);
    end
  endtask

  task automatic test_wrap();
    int wraps;
    cyc(1, 0, 0);
    cyc(0, 0, 1);
    checks++;
    if (o_time !== 36'd0 || o_running !== 1'b0) begin
      errors++;
      $display("FAIL wrap_setup got time=%h run=%b exp 0/0", o_time, o_running);
    end
    force dut.time_q = 36'h995959998;
    m_ms = MAXMS - 2;
    cyc(0, 0, 0);
    release dut.time_q;
    checks++;
    if (o_time !== 36'h995959998) begin
      errors++;
      $display("FAIL wrap_preload got=%h exp=995959998", o_time);
    end
    cyc(1, 0, 0);
    wraps = 0;
    for (int i = 1; i <= 11; i++) begin
      cyc(0, 0, 0);
      if (o_wrap === 1'b1) wraps++;
      checks++;
      if (o_wrap !== m_wrap || o_time !== to_bcd(m_ms)) begin
        errors++;
        $display("FAIL wrap_cycle%0d got wrap=%b time=%h exp wrap=%b time=%h",
                 i, o_wrap, o_time, m_wrap, to_bcd(m_ms));
      end
      if (i == 8) begin
        checks++;
        if (o_time !== 36'd0 || o_wrap !== 1'b1 || o_running !== 1'b1) begin
          errors++;
          $display("FAIL wrap_zero got time=%h wrap=%b run=%b exp 0/1/1", o_time, o_wrap, o_running);
        end
      end
    end
    checks++;
    if (wraps != 1) begin
      errors++;
      $display("FAIL wrap_count got=%0d exp=1", wraps);
    end
  endtask

  task automatic test_lap();
    cyc(0, 0, 1);
    repeat (2345 * TD) cyc(0, 0, 0);
    checks++;
    if (o_time !== 36'h000002345) begin
      errors++;
      $display("FAIL lap_setup got=%h exp=000002345", o_time);
    end
    cyc(0, 1, 0);
    for (int i = 0; i < 200; i++) begin
      stb = 1'b1;
      px  = 10'($urandom_range(X0 + 9*P, 0));
      py  = 9'($urandom_range(Y0 + 3*T + 2*L + 4, Y0 - 4));
      cyc(0, 0, 0);
      checks++;
      if (rgb !== m_rgb) begin
        errors++;
        $display("FAIL lap_pixel x=%0d y=%0d got=%h exp=%h", px, py, rgb, m_rgb);
      end
    end
    checks++;
    if (o_lap !== 1'b1 || o_time !== to_bcd(m_ms) || o_time === 36'h000002345) begin
      errors++;
      $display("FAIL lap_live got lap=%b time=%h exp lap=1 time=%h", o_lap, o_time, to_bcd(m_ms));
    end
    // Digit 7 held at 4 has no segment a; live value there is 9.
    stb = 1'b1; px = 10'(X0 + 7*P + T + 1); py = 9'(Y0 + 1);
    cyc(0, 0, 0);
    checks++;
    if (rgb !== BG) begin
      errors++;
      $display("FAIL lap_hold_seg got=%h exp=%h", rgb, BG);
    end
    cyc(0, 1, 0);
    cyc(0, 0, 0);
    stb = 1'b1; px = 10'(X0 + 7*P + T + 1); py = 9'(Y0 + 1);
    cyc(0, 0, 0);
    checks++;
    if (rgb !== FG || o_lap !== 1'b0) begin
      errors++;
      $display("FAIL lap_release got rgb=%h lap=%b exp rgb=%h lap=0", rgb, o_lap, FG);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    n = 0;
    while (m_presc != TD - 1 && n < 10) begin
      cyc(0, 0, 0);
      n++;
    end
    checks++;
    if (m_presc != TD - 1) begin
      errors++;
      $display("FAIL simul_align got presc=%0d exp=%0d", m_presc, TD - 1);
    end
    cyc(1, 1, 1);
    checks++;
    if (o_time !== 36'd0 || o_lap !== 1'b0 || o_running !== 1'b0 || o_wrap !== 1'b0) begin
      errors++;
      $display("FAIL simul_clear got time=%h lap=%b run=%b wrap=%b exp 0/0/0/0",
               o_time, o_lap, o_running, o_wrap);
    end
    repeat (10) cyc(0, 0, 0);
    checks++;
    if (o_time !== 36'd0) begin
      errors++;
      $display("FAIL simul_hold got=%h exp=0", o_time);
    end
  endtask

  task automatic test_stop_resume();
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    repeat (100) cyc(0, 0, 0);
    checks++;
    if (o_time !== 36'd0 || o_running !== 1'b0) begin
      errors++;
      $display("FAIL stop_hold got time=%h run=%b exp 0/0", o_time, o_running);
    end
    cyc(1, 0, 0);
    checks++;
    if (o_time !== 36'd0) begin
      errors++;
      $display("FAIL resume_edge got=%h exp=0", o_time);
    end
    cyc(0, 0, 0);
    checks++;
    if (o_time !== 36'h000000001 || o_time !== to_bcd(m_ms)) begin
      errors++;
      $display("FAIL resume_tick got=%h exp=000000001", o_time);
    end
  endtask

  task automatic test_render();
    int n;
    cyc(1, 0, 0);
    cyc(0, 0, 1);
    stb = 1'b1; px = 10'(X0 + T + 1); py = 9'(Y0 + 1);
    cyc(0, 0, 0);
    checks++;
    if (rgb !== FG) begin
      errors++;
      $display("FAIL render_seg_a got=%h exp=%h", rgb, FG);
    end
    stb = 1'b1; px = 10'(X0 + T + 1); py = 9'(Y0 + T + L + 1);
    cyc(0, 0, 0);
    checks++;
    if (rgb !== BG) begin
      errors++;
      $display("FAIL render_seg_g got=%h exp=%h", rgb, BG);
    end
    stb = 1'b1; px = 10'(X0 + P + 2*T + L + T/2 + 1); py = 9'(Y0 + L/2 + 1);
    cyc(0, 0, 0);
    checks++;
    if (rgb !== FG) begin
      errors++;
      $display("FAIL render_colon_stopped got=%h exp=%h", rgb, FG);
    end
    stb = 1'b0; px = 10'(X0 + T + 1); py = 9'(Y0 + T + L + 1);
    cyc(0, 0, 0);
    checks++;
    if (rgb !== FG) begin
      errors++;
      $display("FAIL render_hold got=%h exp=%h", rgb, FG);
    end
    stb = 1'b1; px = 10'(X0 + 5*P + 2*T + L + T/2 + 1); py = 9'(Y0 + 2*T + 2*L + 1);
    cyc(0, 0, 0);
    checks++;
    if (rgb !== FG) begin
      errors++;
      $display("FAIL render_dp got=%h exp=%h", rgb, FG);
    end
    cyc(1, 0, 0);
    n = 0;
    while (((m_ms % 1000) / 100) != 6 && n < 5000) begin
      cyc(0, 0, 0);
      n++;
    end
    checks++;
    if (((m_ms % 1000) / 100) != 6) begin
      errors++;
      $display("FAIL render_wait got m2=%0d exp=6", (m_ms % 1000) / 100);
    end
    stb = 1'b1; px = 10'(X0 + 3*P + 2*T + L + T/2 + 1); py = 9'(Y0 + 2*T + 3*L/2 - T + 1);
    cyc(0, 0, 0);
    checks++;
    if (rgb !== BG) begin
      errors++;
      $display("FAIL render_colon_blink got=%h exp=%h", rgb, BG);
    end
    for (int i = 0; i < 150; i++) begin
      stb = 1'b1;
      px  = 10'($urandom_range(X0 + 9*P, 0));
      py  = 9'($urandom_range(Y0 + 3*T + 2*L + 4, Y0 - 4));
      cyc(0, 0, 0);
      checks++;
      if (rgb !== m_rgb) begin
        errors++;
        $display("FAIL render_pixel x=%0d y=%0d got=%h exp=%h", px, py, rgb, m_rgb);
      end
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_run();
    test_wrap();
    test_lap();
    test_back_to_back();
    test_stop_resume();
    test_render();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
